// File: rtl/counter_sequence_controller.sv
// counter_sequence_controller
//
// Runs a WIDTH-bit up/down counter through one programmed run.
// A run is started with a start/ready handshake, steps toward a target at a
// prescaled rate, and ends with a one-cycle done pulse.
//
// Optional build macro: AUTO_RELOAD_EN.
//   When defined, DONE reloads the captured start value and begins another run
//   instead of returning to IDLE. The run repeats until abort or reset.
//
// Ports
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high reset
//   start     in   run request; accepted only while ready=1
//   ready     out  high in IDLE
//   dir       in   1 = count up, 0 = count down; captured on accepted start
//   load_val  in   initial count; captured on accepted start
//   target    in   terminal count; captured on accepted start
//   pause     in   level; freezes stepping and the prescaler in RUN
//   abort     in   ends the run and returns to IDLE; q holds its value
//   q         out  current count (registered)
//   busy      out  high in RUN
//   done      out  one-cycle pulse, high in DONE
//   wrap      out  one-cycle pulse, high together with the wrapped q value
module counter_sequence_controller #(
  parameter int WIDTH    = 3,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             ready,
  input  logic             dir,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] target,
  input  logic             pause,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  // The prescaler needs at least one bit, even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             wrap_q, wrap_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] load_q, load_d;
  logic [WIDTH-1:0] target_q, target_d;

  // Value that q takes if a step happens this cycle.
  logic [WIDTH-1:0] step_val;
  assign step_val = dir_q ? (q_q + WIDTH'(1)) : (q_q - WIDTH'(1));

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      q_q      <= '0;
      presc_q  <= '0;
      wrap_q   <= 1'b0;
      dir_q    <= 1'b0;
      load_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      presc_q  <= presc_d;
      wrap_q   <= wrap_d;
      dir_q    <= dir_d;
      load_q   <= load_d;
      target_q <= target_d;
    end
  end

  // Next-state and datapath logic. abort outranks start and stepping.
  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    presc_d  = presc_q;
    wrap_d   = 1'b0;
    dir_d    = dir_q;
    load_d   = load_q;
    target_d = target_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          dir_d    = dir;
          load_d   = load_val;
          target_d = target;
          q_d      = load_val;
          presc_d  = '0;
          state_d  = (load_val == target) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (!pause) begin
          if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            q_d     = step_val;
            // Wrap is flagged on the step that crosses the all-ones/zero seam.
            wrap_d  = dir_q ? (q_q == {WIDTH{1'b1}}) : (q_q == '0);
            if (step_val == target_q) state_d = S_DONE;
          end else begin
            presc_d = presc_q + PW'(1);
          end
        end
      end
      S_DONE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
`ifdef AUTO_RELOAD_EN
          q_d     = load_q;
          presc_d = '0;
          state_d = (load_q == target_q) ? S_DONE : S_RUN;
`else
          state_d = S_IDLE;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode.
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q == S_RUN);
    done  = (state_q == S_DONE);
    q     = q_q;
    wrap  = wrap_q;
  end

endmodule

// File: tb/tb_counter_sequence_controller.sv
module tb_counter_sequence_controller;

  logic       clk = 1'b0;
  logic       reset, start, dir, pause, abort;
  logic [2:0] load_val, target;

  logic       ready1, busy1, done1, wrap1;
  logic [2:0] q1;
  logic       ready3, busy3, done3, wrap3;
  logic [2:0] q3;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  counter_sequence_controller #(.WIDTH(3), .PRESCALE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .ready(ready1), .dir(dir),
    .load_val(load_val), .target(target), .pause(pause), .abort(abort),
    .q(q1), .busy(busy1), .done(done1), .wrap(wrap1)
  );

  counter_sequence_controller #(.WIDTH(3), .PRESCALE(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .ready(ready3), .dir(dir),
    .load_val(load_val), .target(target), .pause(pause), .abort(abort),
    .q(q3), .busy(busy3), .done(done3), .wrap(wrap3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
  endtask

  // Pulse start for one cycle; returns in cycle 1 of the run.
  task automatic go(input logic d, input logic [2:0] l, input logic [2:0] t);
    dir = d; load_val = l; target = t; start = 1'b1;
    cyc();
    start = 1'b0;
    $display("run dir=%0d load=%0d target=%0d", d, l, t);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dir = 1'b0; pause = 1'b0; abort = 1'b0;
    load_val = '0; target = '0;

    // 1. reset for two cycles, then release
    cyc(); cyc();
    reset = 1'b0;
    cyc();
    chk("rst_q", q1, 0);
    chk("rst_ready", ready1, 1);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_wrap", wrap1, 0);

    // reset asserted mid-run
    go(1'b1, 3'd2, 3'd5);
    cyc();
    chk("mid_q_before", q1, 3);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    chk("mid_q", q1, 0);
    chk("mid_ready", ready1, 1);
    chk("mid_busy", busy1, 0);
    chk("mid_done", done1, 0);
    chk("mid_wrap", wrap1, 0);

    // 2. up count 2 -> 5
    do_reset();
    go(1'b1, 3'd2, 3'd5);
    chk("t2_c1_q", q1, 2); chk("t2_c1_busy", busy1, 1);
    cyc(); chk("t2_c2_q", q1, 3); chk("t2_c2_busy", busy1, 1);
    cyc(); chk("t2_c3_q", q1, 4); chk("t2_c3_busy", busy1, 1);
    cyc(); chk("t2_c4_q", q1, 5); chk("t2_c4_done", done1, 1); chk("t2_c4_busy", busy1, 0);
    cyc();
`ifdef AUTO_RELOAD_EN
    chk("t2_c5_q_reload", q1, 2); chk("t2_c5_busy", busy1, 1); chk("t2_c5_ready", ready1, 0);
`else
    chk("t2_c5_ready", ready1, 1); chk("t2_c5_done", done1, 0);
`endif

    // 3. down count 1 -> 6 through the wrap
    do_reset();
    go(1'b0, 3'd1, 3'd6);
    chk("t3_c1_q", q1, 1);
    cyc(); chk("t3_c2_q", q1, 0); chk("t3_c2_wrap", wrap1, 0);
    cyc(); chk("t3_c3_q", q1, 7); chk("t3_c3_wrap", wrap1, 1);
    cyc(); chk("t3_c4_q", q1, 6); chk("t3_c4_done", done1, 1); chk("t3_c4_wrap", wrap1, 0);

    // up count 6 -> 1 through the wrap
    do_reset();
    go(1'b1, 3'd6, 3'd1);
    chk("up_wrap_c1_q", q1, 6);
    cyc(); chk("up_wrap_c2_q", q1, 7); chk("up_wrap_c2_wrap", wrap1, 0);
    cyc(); chk("up_wrap_c3_q", q1, 0); chk("up_wrap_c3_wrap", wrap1, 1);
    cyc(); chk("up_wrap_c4_q", q1, 1); chk("up_wrap_c4_done", done1, 1); chk("up_wrap_c4_wrap", wrap1, 0);

    // 4. pause in cycles 2-3
    do_reset();
    go(1'b1, 3'd0, 3'd3);
    chk("t4_c1_q", q1, 0);
    cyc(); pause = 1'b1; chk("t4_c2_q", q1, 1);
    cyc(); chk("t4_c3_q", q1, 1);
    cyc(); pause = 1'b0; chk("t4_c4_q", q1, 1); chk("t4_c4_busy", busy1, 1);
    cyc(); chk("t4_c5_q", q1, 2); chk("t4_c5_done", done1, 0);
    cyc(); chk("t4_c6_q", q1, 3); chk("t4_c6_done", done1, 1);

    // 5. start re-pulse ignored, abort in cycle 2
    do_reset();
    go(1'b1, 3'd0, 3'd7);
    start = 1'b1;
    chk("t5_c1_q", q1, 0); chk("t5_c1_busy", busy1, 1); chk("t5_c1_done", done1, 0);
    cyc(); start = 1'b0;
    chk("t5_c2_q", q1, 1); chk("t5_c2_done", done1, 0);
    abort = 1'b1;
    cyc(); abort = 1'b0;
    chk("t5_c3_ready", ready1, 1); chk("t5_c3_q", q1, 1); chk("t5_c3_done", done1, 0);
    cyc();
    chk("t5_c4_ready", ready1, 1); chk("t5_c4_q", q1, 1); chk("t5_c4_done", done1, 0);

    // abort in IDLE blocks start
    abort = 1'b1; start = 1'b1; load_val = 3'd5; target = 3'd6;
    cyc();
    abort = 1'b0; start = 1'b0;
    chk("idle_abort_ready", ready1, 1); chk("idle_abort_q", q1, 1);

    // zero-length run
    do_reset();
    go(1'b1, 3'd4, 3'd4);
    chk("zl_c1_q", q1, 4); chk("zl_c1_done", done1, 1); chk("zl_c1_busy", busy1, 0);
    cyc();
    chk("zl_c2_busy", busy1, 0); chk("zl_c2_q", q1, 4);
`ifdef AUTO_RELOAD_EN
    chk("zl_c2_done", done1, 1);
`else
    chk("zl_c2_ready", ready1, 1);
`endif

    // 6. PRESCALE=3 instance, up 0 -> 2
    do_reset();
    go(1'b1, 3'd0, 3'd2);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("t6_c%0d_q", c), q3, 0);
      chk($sformatf("t6_c%0d_busy", c), busy3, 1);
      cyc();
    end
    for (int c = 4; c <= 6; c++) begin
      chk($sformatf("t6_c%0d_q", c), q3, 1);
      chk($sformatf("t6_c%0d_done", c), done3, 0);
      cyc();
    end
    chk("t6_c7_q", q3, 2); chk("t6_c7_done", done3, 1);
    cyc();
`ifdef AUTO_RELOAD_EN
    chk("t6_c8_q", q3, 0); chk("t6_c8_busy", busy3, 1);
    for (int c = 9; c <= 13; c++) begin
      cyc();
      chk($sformatf("t6_c%0d_done", c), done3, 0);
    end
    cyc();
    chk("t6_c14_q", q3, 2); chk("t6_c14_done", done3, 1);
`else
    chk("t6_c8_ready", ready3, 1); chk("t6_c8_q", q3, 2); chk("t6_c8_done", done3, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
